// File: rtl/pa_f_spsram_acc_ctrl.sv
// Access controller for a single-port SRAM: clears the array after reset or clr, then converts a
// valid/ready request stream into SRAM pin activity and returns read data on a valid/ready channel.
module pa_f_spsram_acc_ctrl #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 45,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  clr,
  output logic                  init_done,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] A,
  output logic                  CEN,
  output logic                  GWEN,
  output logic [DATA_WIDTH-1:0] WEN,
  output logic [DATA_WIDTH-1:0] D,
  input  logic [DATA_WIDTH-1:0] Q
);

  localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH + 1)'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_IDLE
  } state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] init_cnt;   // one spare bit so the sweep never wraps back onto entry 0
  logic                rd_pend;
  logic                req_hs;
  logic                rd_hs;

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_rdy = 1'b0;
    if (!RST && state == S_IDLE && !clr)
      req_rdy = req_wr | (!rd_pend & (!rsp_vld | rsp_rdy));
  end

  assign req_hs = req_vld & req_rdy;
  assign rd_hs  = req_hs & ~req_wr;

  // SRAM pins follow the accepted request in the handshake cycle; the sweep owns them during INIT.
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = req_addr;
    D    = req_wdata;
    if (!RST) begin
      if (state == S_INIT) begin
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
        A    = init_cnt[ADDR_WIDTH-1:0];
        D    = INIT_VAL;
      end else if (req_hs) begin
        CEN  = 1'b0;
        GWEN = ~req_wr;
        WEN  = req_wr ? ~req_wmask : '1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_INIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
      rd_pend   <= 1'b0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rd_pend <= rd_hs;

      // Q is valid the cycle after the read access; hold it until the consumer takes it.
      if (rd_pend) begin
        rsp_vld   <= 1'b1;
        rsp_rdata <= Q;
      end else if (rsp_rdy) begin
        rsp_vld <= 1'b0;
      end

      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state     <= S_IDLE;
            init_done <= 1'b1;
          end
        end
        S_IDLE: begin
          if (clr && !rd_pend && !rsp_vld) begin
            state     <= S_INIT;
            init_cnt  <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pa_f_spsram_acc_ctrl.sv
// Self-checking bench for pa_f_spsram_acc_ctrl: SRAM array model, transaction-level reference
// model compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_pa_f_spsram_acc_ctrl;

  localparam int            AW       = 6;
  localparam int            DW       = 45;
  localparam int            DEPTH    = 2 ** AW;
  localparam logic [DW-1:0] INIT_VAL = '0;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          clr = 1'b0;
  logic          init_done;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          rsp_vld;
  logic          rsp_rdy = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] Q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  pa_f_spsram_acc_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VAL(INIT_VAL)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .init_done(init_done),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .A(A), .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // Single-port SRAM array: bit-masked write, registered read.
  logic [DW-1:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] = rand_dw();
  always @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) sram[A] <= (sram[A] & WEN) | (D & ~WEN);
      else       Q <= sram[A];
    end
  end

  // Reference model: clearing sweep position, golden contents, and at most one read in flight
  // identified by its accept cycle; the response becomes visible two cycles after acceptance.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            m_known = 1'b0;
  bit            m_init, m_done, m_busy, m_acc, m_drain;
  int            m_sweep, m_cyc = 0, m_acc_cyc;
  logic [DW-1:0] m_rsp;

  function automatic bit rsp_visible();
    return m_busy && (m_cyc >= m_acc_cyc + 2);
  endfunction

  function automatic bit exp_rdy();
    return !RST && !m_init && !clr && (req_wr || !m_busy || (rsp_visible() && rsp_rdy));
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      m_known = 1'b1;
      m_init  = 1'b1;
      m_sweep = 0;
      m_done  = 1'b0;
      m_busy  = 1'b0;
    end else if (m_known) begin
      m_acc   = req_vld && exp_rdy();
      m_drain = rsp_visible() && rsp_rdy;
      if (m_init) begin
        ref_mem[m_sweep] = INIT_VAL;
        if (m_sweep == DEPTH - 1) begin
          m_init = 1'b0;
          m_done = 1'b1;
        end
        m_sweep++;
      end else if (clr && !m_busy) begin
        m_init  = 1'b1;
        m_sweep = 0;
        m_done  = 1'b0;
      end
      if (m_drain) m_busy = 1'b0;
      if (m_acc) begin
        if (req_wr) begin
          ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        end else begin
          m_busy    = 1'b1;
          m_acc_cyc = m_cyc;
          m_rsp     = ref_mem[req_addr];
        end
      end
    end
    m_cyc++;
  end

  logic          e_cen, e_gwen, e_acc;
  logic [DW-1:0] e_wen;

  always @(negedge CLK) begin
    if (m_known) begin
      e_acc = req_vld && exp_rdy();
      check("req_rdy", req_rdy, exp_rdy());
      check("init_done", init_done, m_done);
      check("rsp_vld", rsp_vld, rsp_visible());
      if (rsp_visible()) check("rsp_rdata", rsp_rdata, m_rsp);
      e_cen  = 1'b1;
      e_gwen = 1'b1;
      e_wen  = '1;
      if (!RST && m_init) begin
        e_cen  = 1'b0;
        e_gwen = 1'b0;
        e_wen  = '0;
        check("init_A", A, 64'(m_sweep));
        check("init_D", D, INIT_VAL);
      end else if (e_acc) begin
        e_cen  = 1'b0;
        e_gwen = ~req_wr;
        e_wen  = req_wr ? ~req_wmask : '1;
        check("acc_A", A, req_addr);
        if (req_wr) check("wr_D", D, req_wdata);
      end
      check("CEN", CEN, e_cen);
      check("GWEN", GWEN, e_gwen);
      check("WEN", WEN, e_wen);
    end
  end

  // Directed helpers; each is entered and left 1 time unit after a rising edge.
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m);
    bit ok = 1'b0;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (req_rdy) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    check("req_accept", ok, 1);
    @(posedge CLK); #1;
    req_vld = 1'b0;
  endtask

  task automatic wait_rsp(output logic [DW-1:0] data, output int lat);
    lat  = 0;
    data = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      if (rsp_vld) begin
        lat  = i;
        data = rsp_rdata;
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic do_read(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    logic [DW-1:0] d;
    int lat;
    do_req(1'b0, a, '0, '0);
    wait_rsp(d, lat);
    check({name, "_lat"}, lat, 2);
    check(name, d, exp);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (init_done) break;
      n++;
    end
    @(posedge CLK); #1;
  endtask

  int            n, lat, rst_left;
  logic [DW-1:0] d;

  initial begin
    // Reset state, then the full clearing sweep with a write request pending throughout.
    @(posedge CLK);
    @(negedge CLK);
    check("rst_init_done", init_done, 0);
    check("rst_rsp_vld", rsp_vld, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_req_rdy", req_rdy, 0);
    check("rst_pins", {CEN, GWEN, WEN}, {2'b11, {DW{1'b1}}});
    req_vld = 1'b1; req_wr = 1'b1; req_addr = '0; req_wdata = '0; req_wmask = '0;
    @(posedge CLK); #1;
    RST = 1'b0;
    wait_init(n);
    check("init_cycles", n, 64);
    req_vld = 1'b0;

    // Full write then read back.
    do_req(1'b1, 6'd5, 45'h1_2345_6789, '1);
    do_read("rd5_full", 6'd5, 45'h1_2345_6789);

    // Partial write onto a cleared entry, then an all-zero mask write.
    do_req(1'b1, 6'd7, '1, 45'h0_0000_00FF);
    do_read("rd7_partial", 6'd7, 45'h0_0000_00FF);
    do_req(1'b1, 6'd7, '1, '0);
    do_read("rd7_mask0", 6'd7, 45'h0_0000_00FF);

    // Back-pressure: response held, next read blocked, writes still flow, drain+accept together.
    rsp_rdy = 1'b0;
    req_vld = 1'b1; req_wr = 1'b0; req_addr = 6'd7;
    @(negedge CLK);
    check("bp_first_rd_rdy", req_rdy, 1);
    @(posedge CLK); #1;
    req_addr = 6'd5;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_rd_blocked", req_rdy, 0);
      if (i >= 1) check("bp_rdata_stable", {rsp_vld, rsp_rdata}, {1'b1, 45'h0_0000_00FF});
      @(posedge CLK); #1;
    end
    req_wr = 1'b1; req_addr = 6'd9; req_wdata = 45'h3; req_wmask = '1;
    @(negedge CLK);
    check("bp_wr_accepted", req_rdy, 1);
    @(posedge CLK); #1;
    req_wr = 1'b0; req_addr = 6'd5; rsp_rdy = 1'b1;
    @(negedge CLK);
    check("bp_drain_accept", {rsp_vld, req_rdy}, 2'b11);
    @(posedge CLK); #1;
    req_vld = 1'b0;
    wait_rsp(d, lat);
    check("bp_rd5_lat", lat, 2);
    check("bp_rd5_data", d, 45'h1_2345_6789);

    // clr in IDLE with nothing outstanding re-runs the sweep.
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    wait_init(n);
    check("clr_init_cycles", n, 64);
    do_read("clr_rd5", 6'd5, '0);
    do_read("clr_rd7", 6'd7, '0);

    // clr while a response is held is ignored.
    do_req(1'b1, 6'd9, 45'h3, '1);
    rsp_rdy = 1'b0;
    do_req(1'b0, 6'd9, '0, '0);
    wait_rsp(d, lat);
    check("hold_rd9", d, 45'h3);
    clr = 1'b1;
    @(negedge CLK);
    check("clr_ign_done0", init_done, 1);
    @(posedge CLK); #1;
    clr = 1'b0;
    @(negedge CLK);
    check("clr_ign_state", {init_done, rsp_vld}, 2'b11);
    rsp_rdy = 1'b1;
    @(posedge CLK); #1;
    do_read("clr_ign_rd9", 6'd9, 45'h3);

    // Reset in the middle of a sweep restarts it at entry 0.
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!CEN && A == 6'd30) break;
    end
    check("mid_init_reached", {CEN, A}, {1'b0, 6'd30});
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("sweep_restart", {CEN, GWEN, A, init_done}, {2'b00, 6'd0, 1'b0});
    @(posedge CLK); #1;
    wait_init(n);
    check("restart_remaining", n, 63);

    // Reset with a read in flight drops the response.
    do_req(1'b0, 6'd9, '0, '0);
    RST = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("rst_rd_drop", rsp_vld, 0);
      @(posedge CLK); #1;
      if (i == 1) RST = 1'b0;
    end
    wait_init(n);
    check("rst_rd_init_rest", n, 60);

    // Random traffic against the reference model.
    rst_left = 0;
    for (int c = 0; c < 4000; c++) begin
      req_vld   = ($urandom_range(0, 3) != 0);
      req_wr    = 1'($urandom_range(0, 1));
      req_addr  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3))
                                              : AW'($urandom_range(0, DEPTH - 1));
      req_wdata = rand_dw();
      case ($urandom_range(0, 3))
        0:       req_wmask = '1;
        1:       req_wmask = '0;
        default: req_wmask = rand_dw();
      endcase
      rsp_rdy = ($urandom_range(0, 9) < 7);
      clr     = ($urandom_range(0, 149) == 0);
      if (rst_left > 0) begin
        RST = 1'b1;
        rst_left--;
      end else if ($urandom_range(0, 799) == 0) begin
        RST = 1'b1;
        rst_left = 1;
      end else begin
        RST = 1'b0;
      end
      @(posedge CLK); #1;
    end
    RST = 1'b0; clr = 1'b0; req_vld = 1'b0; rsp_rdy = 1'b1;
    repeat (80) @(posedge CLK);
    #1;
    check("final_init_done", init_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
